// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared constants, decode targets and helpers for the
// data-memory responder.
//   XLEN            datapath width
//   DMEM_MMIO_BASE  base of the MMIO register page
//   DMEM_*_OFF      byte offsets of the MMIO registers within the page
//   target_e        decoded destination of an address
//   decode_target   maps a byte address to a target_e
//   lane_merge      byte-lane masked update of a 32-bit word
package dmem_responder_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DMEM_MMIO_BASE = 32'hFFFF_0000;
    localparam logic [XLEN-1:0] DMEM_LED_OFF   = 32'h0000_0000;
    localparam logic [XLEN-1:0] DMEM_CYCLO_OFF = 32'h0000_0004;
    localparam logic [XLEN-1:0] DMEM_CYCHI_OFF = 32'h0000_0008;
    localparam logic [XLEN-1:0] DMEM_HALT_OFF  = 32'h0000_000C;

    typedef enum logic [2:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_LED,
        TGT_CYCLO,
        TGT_CYCHI,
        TGT_HALT
    } target_e;

    // addr[1:0] never affects the result: RAM size is a multiple of 4 and
    // MMIO registers are matched on word offsets only.
    function automatic target_e decode_target(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] ram_bytes,
        input logic            mmio_en
    );
        target_e    t;
        logic [3:0] off;
        t   = TGT_NONE;
        off = {a[3:2], 2'b00};
        if (a < ram_bytes) begin
            t = TGT_RAM;
        end else if (mmio_en && (a[XLEN-1:4] == DMEM_MMIO_BASE[XLEN-1:4])) begin
            if (off == DMEM_LED_OFF[3:0])        t = TGT_LED;
            else if (off == DMEM_CYCLO_OFF[3:0]) t = TGT_CYCLO;
            else if (off == DMEM_CYCHI_OFF[3:0]) t = TGT_CYCHI;
            else                                 t = TGT_HALT;
        end
        return t;
    endfunction

    function automatic logic [XLEN-1:0] lane_merge(
        input logic [XLEN-1:0] old_w,
        input logic [XLEN-1:0] new_w,
        input logic [3:0]      lanes
    );
        logic [XLEN-1:0] r;
        r = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH-word data RAM, synchronous byte-lane write, asynchronous
// read, no reset.
//   clk      write clock
//   lane_we  per-byte write enables (bit i writes wdata[8i+7:8i])
//   index    word index
//   wdata    write data
//   rdata    word at index (combinational)
module dmem_ram
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [3:0]        lane_we,
    input  logic [ADDR_W-1:0] index,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (lane_we[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's data-memory port.
// Decodes the byte address into data RAM, an optional MMIO register page
// (LED, 64-bit cycle counter, halt latch) or unmapped space; reads are
// combinational, stores commit on the rising clock edge.
// Optional feature macro: DMEM_MMIO_EN (MMIO page, counter and halt logic).
//   clk      core clock
//   reset    asynchronous active-low reset
//   addr     byte address
//   wdata    lane-aligned store data
//   we       store strobe
//   amp      byte-lane enables
//   rdata    full word at addr[31:2]
//   led_out  LED register
//   halt     sticky halt latch
//   err      sticky flag: a store decoded to no target
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            we,
    input  logic [3:0]      amp,
    output logic [XLEN-1:0] rdata,
    output logic [31:0]     led_out,
    output logic            halt,
    output logic            err
);

    localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(DEPTH * 4);

`ifdef DMEM_MMIO_EN
    localparam logic MMIO_EN = 1'b1;
`else
    localparam logic MMIO_EN = 1'b0;
`endif

    target_e         tgt;
    logic [3:0]      ram_lane_we;
    logic [XLEN-1:0] ram_rdata;

    always_comb begin
        tgt         = decode_target(addr, RAM_BYTES, MMIO_EN);
        ram_lane_we = (we && (tgt == TGT_RAM)) ? amp : '0;
    end

    dmem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .lane_we (ram_lane_we),
        .index   (addr[ADDR_W+1:2]),
        .wdata   (wdata),
        .rdata   (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (we && (tgt == TGT_NONE)) begin
            err <= 1'b1;
        end
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] led_q;
    logic        halt_q;
    logic [63:0] cycle_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q       <= '0;
            halt_q      <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (we && (tgt == TGT_LED)) begin
                led_q <= lane_merge(led_q, wdata, amp);
            end
            if (we && (tgt == TGT_HALT) && amp[0] && wdata[0]) begin
                halt_q <= 1'b1;
            end
            if (!halt_q) begin
                cycle_count <= cycle_count + 64'd1;
            end
        end
    end

    assign led_out = led_q;
    assign halt    = halt_q;
`else
    assign led_out = '0;
    assign halt    = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (tgt)
            TGT_RAM:   rdata = ram_rdata;
`ifdef DMEM_MMIO_EN
            TGT_LED:   rdata = led_q;
            TGT_CYCLO: rdata = cycle_count[31:0];
            TGT_CYCHI: rdata = cycle_count[63:32];
            TGT_HALT:  rdata = {31'b0, halt_q};
`endif
            default:   rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// MMIO-specific scenarios follow the DMEM_MMIO_EN macro of the build.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  amp;
    logic [31:0] rdata;
    logic [31:0] led_out;
    logic        halt;
    logic        err;

    int errors = 0;
    int checks = 0;

    dmem_responder #(
        .DEPTH (1024)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .amp     (amp),
        .rdata   (rdata),
        .led_out (led_out),
        .halt    (halt),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        amp   = m;
        we    = 1'b1;
        step();
        we    = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        amp   = 4'h0;
        repeat (2) step();
        checks++; if (led_out !== 32'h0) begin errors++; $display("FAIL reset_led: got %h expected %h", led_out, 32'h0); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`ifdef DMEM_MMIO_EN
        addr = 32'hFFFF_0004;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_cyclo: got %h expected %h", rdata, 32'h0); end
        reset = 1'b1;
        step();
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL first_count: got %h expected %h", rdata, 32'h1); end
        step();
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL second_count: got %h expected %h", rdata, 32'h2); end
`else
        addr = 32'hFFFF_0004;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL nommio_cyclo_read: got %h expected %h", rdata, 32'h0); end
        reset = 1'b1;
        step();
`endif
    endtask

    task automatic test_ram_write();
        store(32'h10, 32'hDEAD_BEEF, 4'hF);
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_full_word: got %h expected %h", rdata, 32'hDEAD_BEEF); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ram_err: got %b expected 0", err); end
        store(32'h14, 32'h1234_5678, 4'hF);
        addr = 32'h17;
        #1;
        checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL ram_low_bits_ignored: got %h expected %h", rdata, 32'h1234_5678); end
        addr = 32'h10;
        #1;
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_neighbour: got %h expected %h", rdata, 32'hDEAD_BEEF); end
        // write cycle shows the old value, new value after the edge
        addr  = 32'h14;
        wdata = 32'hCAFE_F00D;
        amp   = 4'hF;
        we    = 1'b1;
        #1;
        checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL ram_old_in_write_cycle: got %h expected %h", rdata, 32'h1234_5678); end
        step();
        we = 1'b0;
        #1;
        checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_new_after_edge: got %h expected %h", rdata, 32'hCAFE_F00D); end
        store(32'h0, 32'h0102_0304, 4'hF);
    endtask

    task automatic test_partial();
        store(32'h10, 32'h00AA_0000, 4'b0100);
        checks++; if (rdata !== 32'hDEAA_BEEF) begin errors++; $display("FAIL partial_lane2: got %h expected %h", rdata, 32'hDEAA_BEEF); end
        store(32'h10, 32'hFFFF_FFFF, 4'b0000);
        checks++; if (rdata !== 32'hDEAA_BEEF) begin errors++; $display("FAIL amp_zero: got %h expected %h", rdata, 32'hDEAA_BEEF); end
        store(32'h10, 32'h0000_0055, 4'b0001);
        checks++; if (rdata !== 32'hDEAA_BE55) begin errors++; $display("FAIL partial_lane0: got %h expected %h", rdata, 32'hDEAA_BE55); end
        store(32'h10, 32'h0000_00EF, 4'b0001);
        checks++; if (rdata !== 32'hDEAA_BEEF) begin errors++; $display("FAIL partial_restore: got %h expected %h", rdata, 32'hDEAA_BEEF); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL partial_err: got %b expected 0", err); end
    endtask

    task automatic test_mmio();
`ifdef DMEM_MMIO_EN
        store(32'hFFFF_0000, 32'h0000_00FF, 4'hF);
        checks++; if (led_out !== 32'h0000_00FF) begin errors++; $display("FAIL led_write: got %h expected %h", led_out, 32'hFF); end
        checks++; if (rdata !== 32'h0000_00FF) begin errors++; $display("FAIL led_read: got %h expected %h", rdata, 32'hFF); end
        store(32'hFFFF_0000, 32'h0000_AB00, 4'b0010);
        checks++; if (led_out !== 32'h0000_ABFF) begin errors++; $display("FAIL led_lane: got %h expected %h", led_out, 32'hABFF); end
        store(32'hFFFF_0000, 32'h0000_00FF, 4'hF);
        store(32'hFFFF_0004, 32'hFFFF_FFFF, 4'hF);
        store(32'hFFFF_0008, 32'hFFFF_FFFF, 4'hF);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cyc_store_err: got %b expected 0", err); end
        store(32'hFFFF_000C, 32'h0000_0000, 4'b0001);
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_data0: got %b expected 0", halt); end
        store(32'hFFFF_000C, 32'h0000_0001, 4'b0010);
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_lane0_off: got %b expected 0", halt); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL halt_read0: got %h expected %h", rdata, 32'h0); end
`else
        addr = 32'hFFFF_0000;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL nommio_led_read: got %h expected %h", rdata, 32'h0); end
        store(32'hFFFF_0000, 32'h0000_00FF, 4'hF);
        checks++; if (led_out !== 32'h0) begin errors++; $display("FAIL nommio_led: got %h expected %h", led_out, 32'h0); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL nommio_err: got %b expected 1", err); end
        store(32'hFFFF_000C, 32'h0000_0001, 4'b0001);
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL nommio_halt: got %b expected 0", halt); end
        reset = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL nommio_err_clear: got %b expected 0", err); end
        step();
        reset = 1'b1;
        step();
`endif
    endtask

    task automatic test_counter_halt();
`ifdef DMEM_MMIO_EN
        force dut.cycle_count = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_count;
        addr = 32'hFFFF_0004;
        #1;
        checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL preset_lo: got %h expected %h", rdata, 32'hFFFF_FFFF); end
        step();
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL carry_lo: got %h expected %h", rdata, 32'h0); end
        addr = 32'hFFFF_0008;
        #1;
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL carry_hi: got %h expected %h", rdata, 32'h1); end
        // this edge still counts (halt was 0 before it): 0x1_0000_0000 -> 0x1_0000_0001
        store(32'hFFFF_000C, 32'h0000_0001, 4'b0001);
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halt); end
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL halt_read1: got %h expected %h", rdata, 32'h1); end
        addr = 32'hFFFF_0004;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL frozen_lo[%0d]: got %h expected %h", i, rdata, 32'h1); end
        end
        addr = 32'hFFFF_0008;
        #1;
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL frozen_hi: got %h expected %h", rdata, 32'h1); end
        store(32'h20, 32'hA5A5_A5A5, 4'hF);
        checks++; if (rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL store_after_halt: got %h expected %h", rdata, 32'hA5A5_A5A5); end
`endif
    endtask

    task automatic test_unmapped();
        addr = 32'h0000_1000;
        we   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL unmapped_idle[%0d]: got rdata=%h err=%b expected rdata=0 err=0", i, rdata, err); end
        end
        store(32'h0000_1000, 32'h5555_5555, 4'hF);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL unmapped_store_err: got %b expected 1", err); end
        addr = 32'h0;
        #1;
        checks++; if (rdata !== 32'h0102_0304) begin errors++; $display("FAIL unmapped_no_alias: got %h expected %h", rdata, 32'h0102_0304); end
        addr = 32'h10;
        #1;
        checks++; if (rdata !== 32'hDEAA_BEEF) begin errors++; $display("FAIL unmapped_ram_intact: got %h expected %h", rdata, 32'hDEAA_BEEF); end
        repeat (3) step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_midrun_reset();
`ifdef DMEM_MMIO_EN
        checks++; if (led_out !== 32'hFF || err !== 1'b1 || halt !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got led=%h err=%b halt=%b expected led=ff err=1 halt=1", led_out, err, halt); end
`endif
        addr  = 32'hFFFF_0004;
        reset = 1'b0;
        #1;
        checks++; if (led_out !== 32'h0) begin errors++; $display("FAIL async_led: got %h expected %h", led_out, 32'h0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err: got %b expected 0", err); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL async_halt: got %b expected 0", halt); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL async_counter: got %h expected %h", rdata, 32'h0); end
        step();
        reset = 1'b1;
        addr  = 32'h10;
        #1;
        checks++; if (rdata !== 32'hDEAA_BEEF) begin errors++; $display("FAIL ram_survives_reset: got %h expected %h", rdata, 32'hDEAA_BEEF); end
    endtask

    initial begin
        test_reset();
        test_ram_write();
        test_partial();
        test_mmio();
        test_counter_halt();
        test_unmapped();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
